// File: rtl/nn_xor_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nn_xor_sched                                                 |
// | Description : Sequences H0, H1 and O of a 2-2-1 XOR network over one       |
// |               shared neuron+sigmoid datapath; holds the nine coefficients. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nn_xor_sched #(
    parameter int SIG_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       x0,
    input  logic       x1,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       cfg_err,
    output logic       nx0,
    output logic       nx1,
    output logic [7:0] nw0,
    output logic [7:0] nw1,
    output logic [7:0] nbias,
    output logic       nvalid,
    input  logic       sig_in,
    output logic       busy,
    output logic       done,
    output logic       y
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_h0   = 3'd1;
    localparam logic [2:0] c_st_h1   = 3'd2;
    localparam logic [2:0] c_st_out  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    localparam logic [2:0] c_last = 3'(SIG_LAT);

    // Entry 8 is the MSB slice: O bias down to H0 w0. Default network is OR/NAND/AND.
    localparam logic [8:0][7:0] c_coef_rst = {
        8'hE2, 8'd20, 8'd20,
        8'd30, 8'hEC, 8'hEC,
        8'hF6, 8'd20, 8'd20
    };

    logic [2:0]       r_state;
    logic [2:0]       r_wait;
    logic [8:0][7:0]  r_coef;
    logic             r_lx0;
    logic             r_lx1;
    logic             r_h0;
    logic             r_h1;
    logic             r_y;
    logic             r_cfg_err;

    logic             w_busy;
    logic             w_last;
    logic             w_addr_ok;

    assign w_busy    = (r_state != c_st_idle);
    assign w_last    = (r_wait == c_last);
    assign w_addr_ok = (cfg_addr <= 4'd8);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_wait    <= 3'd0;
            r_coef    <= c_coef_rst;
            r_lx0     <= 1'b0;
            r_lx1     <= 1'b0;
            r_h0      <= 1'b0;
            r_h1      <= 1'b0;
            r_y       <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && (w_busy || !w_addr_ok);
            if (cfg_we && !w_busy && w_addr_ok) begin
                r_coef[cfg_addr] <= cfg_data;
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_lx0   <= x0;
                        r_lx1   <= x1;
                        r_wait  <= 3'd0;
                        r_state <= c_st_h0;
                    end
                end
                c_st_h0, c_st_h1, c_st_out: begin
                    if (w_last) begin
                        r_wait <= 3'd0;
                        case (r_state)
                            c_st_h0: begin
                                r_h0    <= sig_in;
                                r_state <= c_st_h1;
                            end
                            c_st_h1: begin
                                r_h1    <= sig_in;
                                r_state <= c_st_out;
                            end
                            default: begin
                                r_y     <= sig_in;
                                r_state <= c_st_done;
                            end
                        endcase
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    // Operands derive only from registers; coefficients are frozen while busy,
    // so the n* bus only moves at state boundaries.
    always_comb begin
        nx0    = 1'b0;
        nx1    = 1'b0;
        nw0    = 8'd0;
        nw1    = 8'd0;
        nbias  = 8'd0;
        nvalid = 1'b0;
        case (r_state)
            c_st_h0: begin
                nx0 = r_lx0; nx1 = r_lx1;
                nw0 = r_coef[0]; nw1 = r_coef[1]; nbias = r_coef[2];
                nvalid = 1'b1;
            end
            c_st_h1: begin
                nx0 = r_lx0; nx1 = r_lx1;
                nw0 = r_coef[3]; nw1 = r_coef[4]; nbias = r_coef[5];
                nvalid = 1'b1;
            end
            c_st_out: begin
                nx0 = r_h0; nx1 = r_h1;
                nw0 = r_coef[6]; nw1 = r_coef[7]; nbias = r_coef[8];
                nvalid = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = w_busy;
    assign done    = (r_state == c_st_done);
    assign y       = r_y;
    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_nn_xor_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nn_xor_sched                                              |
// | Description : Directed self-checking bench for nn_xor_sched, SIG_LAT 0/2.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nn_xor_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // SIG_LAT = 0 instance
    logic       start = 1'b0, x0 = 1'b0, x1 = 1'b0, cfg_we = 1'b0;
    logic [3:0] cfg_addr = 4'd0;
    logic [7:0] cfg_data = 8'd0;
    logic       cfg_err, nx0, nx1, nvalid, sig_in, busy, done, y;
    logic [7:0] nw0, nw1, nbias;

    // SIG_LAT = 2 instance
    logic       start_2 = 1'b0, x0_2 = 1'b0, x1_2 = 1'b0, cfg_we_2 = 1'b0;
    logic [3:0] cfg_addr_2 = 4'd0;
    logic [7:0] cfg_data_2 = 8'd0;
    logic       cfg_err_2, nx0_2, nx1_2, nvalid_2, sig_in_2, busy_2, done_2, y_2;
    logic [7:0] nw0_2, nw1_2, nbias_2;
    logic       d1_2 = 1'b0, d2_2 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    nn_xor_sched #(.SIG_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .x1(x1),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .nx0(nx0), .nx1(nx1), .nw0(nw0), .nw1(nw1), .nbias(nbias), .nvalid(nvalid),
        .sig_in(sig_in), .busy(busy), .done(done), .y(y)
    );

    nn_xor_sched #(.SIG_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_2), .x0(x0_2), .x1(x1_2),
        .cfg_we(cfg_we_2), .cfg_addr(cfg_addr_2), .cfg_data(cfg_data_2), .cfg_err(cfg_err_2),
        .nx0(nx0_2), .nx1(nx1_2), .nw0(nw0_2), .nw1(nw1_2), .nbias(nbias_2), .nvalid(nvalid_2),
        .sig_in(sig_in_2), .busy(busy_2), .done(done_2), .y(y_2)
    );

    function automatic logic neuron(input logic a, input logic b,
                                    input logic [7:0] w0, input logic [7:0] w1,
                                    input logic [7:0] bias);
        int s;
        s = int'($signed(bias));
        if (a) s = s + int'($signed(w0));
        if (b) s = s + int'($signed(w1));
        return (s > 0);
    endfunction

    assign sig_in   = neuron(nx0, nx1, nw0, nw1, nbias);
    assign sig_in_2 = d2_2;
    always @(posedge clk) begin
        d1_2 <= neuron(nx0_2, nx1_2, nw0_2, nw1_2, nbias_2);
        d2_2 <= d1_2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Starts a run on the SIG_LAT=0 instance; returns the negedge index of done.
    task automatic run0(input logic a, input logic b, output int lat);
        x0 = a; x1 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int lat, cnt, first, second, stab_err, vcnt;
        logic [25:0] snap;
        logic [3:0][1:0] xv;
        logic [3:0] yv;
        xv = {2'b11, 2'b10, 2'b01, 2'b00};
        yv = 4'b0110;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y", y, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_nvalid", nvalid, 0);
        check("rst_operands", {nx0, nx1, nw0, nw1, nbias}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Default XOR truth table, latency 4
        for (int i = 0; i < 4; i++) begin
            run0(xv[i][1], xv[i][0], lat);
            check("xor_y", y, yv[i]);
            check("xor_lat", lat, 4);
        end

        // Operand sequence for (1,0): H0 -> H1 -> OUT with h0=1, h1=1
        x0 = 1'b1; x1 = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("h0_ops", {nvalid, nx0, nx1, nw0, nw1, nbias}, {3'b110, 8'd20, 8'd20, 8'hF6});
        @(negedge clk);
        check("h1_ops", {nvalid, nx0, nx1, nw0, nw1, nbias}, {3'b110, 8'hEC, 8'hEC, 8'd30});
        @(negedge clk);
        check("out_ops", {nvalid, nx0, nx1, nw0, nw1, nbias}, {3'b111, 8'd20, 8'd20, 8'hE2});
        @(negedge clk);
        check("done_busy", {done, busy, nvalid}, 3'b110);
        @(negedge clk);

        // Reprogram O to OR: (1,1) -> h0=1, h1=0, y=1
        cfg_write(4'd6, 8'd20);
        cfg_write(4'd7, 8'd20);
        cfg_write(4'd8, 8'hF6);
        x0 = 1'b1; x1 = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("or_out_hidden", {nx0, nx1, nbias}, {2'b10, 8'hF6});
        @(negedge clk);
        check("or_y", y, 1);
        @(negedge clk);

        // Invalid address: error pulse, no effect
        cfg_write(4'd9, 8'h80);
        check("bad_addr_err", cfg_err, 1);
        @(negedge clk);
        check("bad_addr_err_clr", cfg_err, 0);
        run0(1'b1, 1'b1, lat);
        check("bad_addr_keep", y, 1);
        cfg_write(4'd8, 8'hE2);

        // Write while busy is dropped; result remains XOR
        x0 = 1'b0; x1 = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd6; cfg_data = 8'h80;
        @(negedge clk);
        cfg_we = 1'b0;
        check("busy_wr_err", cfg_err, 1);
        check("busy_wr_w0", nw0, 8'd20);
        @(negedge clk);
        check("busy_wr_y", {done, y}, 2'b11);
        @(negedge clk);

        // start pulsed during H1 is ignored
        x0 = 1'b1; x1 = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (done) cnt++;
            @(negedge clk);
        end
        check("ignored_start_dones", cnt, 1);

        // start held high: back-to-back with one IDLE cycle
        x0 = 1'b1; x1 = 1'b0; start = 1'b1;
        first = 0; second = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
            if (first != 0 && n == first + 1) check("b2b_idle_gap", busy, 0);
        end
        start = 1'b0;
        check("b2b_first", first, 4);
        check("b2b_second", second, 9);
        repeat (6) @(negedge clk);
        check("b2b_y", y, 1);

        // Make O an OR, then reset during OUT: defaults must come back
        cfg_write(4'd8, 8'hF6);
        x0 = 1'b1; x1 = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", {done, y, busy, nvalid}, 4'b0000);
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("rst_mid_no_done", cnt, 0);
        run0(1'b1, 1'b1, lat);
        check("rst_default_11", y, 0);
        run0(1'b0, 1'b1, lat);
        check("rst_default_01", y, 1);

        // SIG_LAT = 2: latency 10, nvalid 9 cycles, operands stable per state
        for (int r = 0; r < 2; r++) begin
            x0_2 = (r == 1); x1_2 = 1'b1; start_2 = 1'b1;
            @(negedge clk); start_2 = 1'b0;
            lat = 0; vcnt = 0; stab_err = 0; snap = '0;
            for (int n = 1; n <= 30; n++) begin
                if (nvalid_2) vcnt++;
                if (n == 1 || n == 4 || n == 7)
                    snap = {nx0_2, nx1_2, nw0_2, nw1_2, nbias_2};
                else if (n <= 9 && snap != {nx0_2, nx1_2, nw0_2, nw1_2, nbias_2})
                    stab_err++;
                if (done_2) begin
                    lat = n;
                    break;
                end
                @(negedge clk);
            end
            check("lat2_done", lat, 10);
            check("lat2_nvalid", vcnt, 9);
            check("lat2_stable", stab_err, 0);
            check("lat2_y", y_2, (r == 1) ? 0 : 1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
